// File: rtl/c17_activity_monitor.sv
// c17_activity_monitor
// Measures per-net switching activity of the C17 benchmark outputs
// (bit0 = 22GAT, bit1 = 23GAT) over a window of 2^WIN_LOG2 sample
// comparisons and hands the toggle counts out over a valid/ready handshake.
// Optional feature: define C17_ACTMON_TOTAL_EN to add res_total, the sum of
// all per-net counts, latched and held together with res_toggles.
module c17_activity_monitor #(
    parameter int OUT_W    = 2,
    parameter int WIN_LOG2 = 8,
    parameter int CNT_W    = WIN_LOG2 + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [OUT_W-1:0]         sig_in,
    output logic                     busy,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [OUT_W*CNT_W-1:0]   res_toggles
`ifdef C17_ACTMON_TOTAL_EN
    ,
    output logic [CNT_W+((OUT_W > 1) ? $clog2(OUT_W) : 1)-1:0] res_total
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_COUNT  = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

    localparam logic [WIN_LOG2-1:0] WIN_LAST = {WIN_LOG2{1'b1}};

    state_t                 state_q, state_d;
    logic [OUT_W-1:0]       prev_q, prev_d;
    logic [WIN_LOG2-1:0]    win_q, win_d;
    logic                   latch_en;

    // Next-count of every net, flattened; this is what gets latched so the
    // comparison made on the final window cycle is part of the result.
    logic [OUT_W*CNT_W-1:0] cnt_next_flat;

    // Next-state logic plus the shared prime/compare bookkeeping.
    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        win_d    = win_q;
        latch_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_PRIME;
                end
            end
            ST_PRIME: begin
                prev_d  = sig_in;
                win_d   = '0;
                state_d = ST_COUNT;
            end
            ST_COUNT: begin
                prev_d = sig_in;
                win_d  = win_q + 1'b1;
                if (win_q == WIN_LAST) begin
                    latch_en = 1'b1;
                    state_d  = ST_REPORT;
                end
            end
            ST_REPORT: begin
                // A new request is only honoured together with the accept,
                // which gives gap-free back-to-back windows.
                if (res_ready) begin
                    state_d = start ? ST_PRIME : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, previous-sample and window-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            prev_q  <= '0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            win_q   <= win_d;
        end
    end

    assign busy      = (state_q == ST_PRIME) || (state_q == ST_COUNT);
    assign res_valid = (state_q == ST_REPORT);

    // One toggle counter and one result register per monitored net.
    generate
        for (genvar gi = 0; gi < OUT_W; gi++) begin : gen_net
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic [CNT_W-1:0] res_q;

            // Clear on prime, add one per observed toggle while counting.
            always_comb begin
                cnt_d = cnt_q;
                if (state_q == ST_PRIME) begin
                    cnt_d = '0;
                end else if (state_q == ST_COUNT) begin
                    cnt_d = cnt_q + CNT_W'(sig_in[gi] ^ prev_q[gi]);
                end
            end

            // Running count and the held result for this net.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                    res_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                    if (latch_en) begin
                        res_q <= cnt_d;
                    end
                end
            end

            assign cnt_next_flat[gi*CNT_W +: CNT_W] = cnt_d;
            assign res_toggles[gi*CNT_W +: CNT_W]   = res_q;
        end
    endgenerate

`ifdef C17_ACTMON_TOTAL_EN
    localparam int TOT_W = CNT_W + ((OUT_W > 1) ? $clog2(OUT_W) : 1);

    logic [TOT_W-1:0] total_sum;
    logic [TOT_W-1:0] total_q;

    // Sum of the final per-net counts, taken from the same values latched
    // into res_toggles.
    always_comb begin
        total_sum = '0;
        for (int i = 0; i < OUT_W; i++) begin
            total_sum = total_sum + TOT_W'(cnt_next_flat[i*CNT_W +: CNT_W]);
        end
    end

    // Held total, updated only at latch time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_q <= '0;
        end else if (latch_en) begin
            total_q <= total_sum;
        end
    end

    assign res_total = total_q;
`else
    // Without the total output the next-count vector only feeds the result
    // registers inside gen_net; nothing else to build here.
`endif

endmodule

// File: tb/tb_c17_activity_monitor.sv
// Directed testbench for c17_activity_monitor with WIN_LOG2=3 (8 comparisons
// per window, 4-bit counters). Define C17_ACTMON_TOTAL_EN to also check
// res_total.
module tb_c17_activity_monitor;

    localparam int OUT_W    = 2;
    localparam int WIN_LOG2 = 3;
    localparam int CNT_W    = WIN_LOG2 + 1;

    logic                   clk;
    logic                   rst_n;
    logic                   start;
    logic [OUT_W-1:0]       sig_in;
    logic                   busy;
    logic                   res_valid;
    logic                   res_ready;
    logic [OUT_W*CNT_W-1:0] res_toggles;
`ifdef C17_ACTMON_TOTAL_EN
    logic [CNT_W:0]         res_total;
`endif

    int checks = 0;
    int errors = 0;

    c17_activity_monitor #(
        .OUT_W    (OUT_W),
        .WIN_LOG2 (WIN_LOG2),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .sig_in      (sig_in),
        .busy        (busy),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_toggles (res_toggles)
`ifdef C17_ACTMON_TOTAL_EN
        ,
        .res_total   (res_total)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs are driven and outputs sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one window. vec holds the 8 comparison samples, sample k in
    // bits [2k+1:2k]. With do_start=0 the caller has already made the start
    // edge happen and the DUT is in PRIME.
    task automatic run_window(input bit do_start, input logic [1:0] prime_val,
                              input logic [15:0] vec, input logic [7:0] exp_tog,
                              input string name);
        if (do_start) begin
            start  = 1'b1;
            sig_in = prime_val;
            step();
            start  = 1'b0;
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy_after_start: got %b expected 1", name, busy);
            end
        end
        sig_in = prime_val;
        step();
        for (int k = 0; k < 8; k++) begin
            sig_in = vec[k*2 +: 2];
            step();
            if (k == 6) begin
                checks++;
                if (res_valid !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s early_valid: got valid=%b busy=%b expected valid=0 busy=1",
                             name, res_valid, busy);
                end
            end
        end
        checks++;
        if (res_valid !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s window_end: got valid=%b busy=%b expected valid=1 busy=0",
                     name, res_valid, busy);
        end
        checks++;
        if (res_toggles !== exp_tog) begin
            errors++;
            $display("FAIL %s toggles: got %h expected %h", name, res_toggles, exp_tog);
        end
`ifdef C17_ACTMON_TOTAL_EN
        checks++;
        if (res_total !== 5'(exp_tog[3:0]) + 5'(exp_tog[7:4])) begin
            errors++;
            $display("FAIL %s total: got %0d expected %0d", name, res_total,
                     exp_tog[3:0] + exp_tog[7:4]);
        end
`endif
        $display("window %s: toggles=%h valid=%b", name, res_toggles, res_valid);
    endtask

    // Accept the pending result and return to IDLE.
    task automatic accept(input string name);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s accept: got valid=%b busy=%b expected 0 0", name, res_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        start     = 1'b1;
        sig_in    = 2'b11;
        res_ready = 1'b0;
        step();
        step();
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || res_toggles !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: got busy=%b valid=%b toggles=%h expected 0 0 00",
                     busy, res_valid, res_toggles);
        end
`ifdef C17_ACTMON_TOTAL_EN
        checks++;
        if (res_total !== 5'd0) begin
            errors++;
            $display("FAIL reset_total: got %0d expected 0", res_total);
        end
`endif
        rst_n = 1'b1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got busy=%b expected 0", busy);
        end
        // start still held: the next edge is the start edge.
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_start_busy: got %b expected 1", busy);
        end
        $display("reset: busy=%b after release with start held", busy);
        run_window(1'b0, 2'b11, 16'hFFFF, 8'h00, "reset_const11");
        accept("reset_const11");
    endtask

    task automatic test_quiet();
        run_window(1'b1, 2'b00, 16'h0000, 8'h00, "quiet");
        accept("quiet");
    endtask

    task automatic test_net0_toggle();
        // 11,10,11,10,... sample 0 in the low bits
        run_window(1'b1, 2'b10, 16'hBBBB, 8'h08, "net0_toggle");
        accept("net0_toggle");
    endtask

    task automatic test_backpressure();
        // bit1: 0,1,1,0,0,1,1,0 ; bit0 fixed 0
        run_window(1'b1, 2'b00, 16'h2828, 8'h40, "net1_half");
        for (int c = 0; c < 5; c++) begin
            start = (c == 2);
            step();
        end
        start = 1'b0;
        checks++;
        if (res_valid !== 1'b1 || busy !== 1'b0 || res_toggles !== 8'h40) begin
            errors++;
            $display("FAIL backpressure_hold: got valid=%b busy=%b toggles=%h expected 1 0 40",
                     res_valid, busy, res_toggles);
        end
        $display("backpressure: held valid=%b toggles=%h", res_valid, res_toggles);
        accept("backpressure");
        checks++;
        if (res_toggles !== 8'h40) begin
            errors++;
            $display("FAIL idle_keeps_result: got %h expected 40", res_toggles);
        end
    endtask

    task automatic test_back_to_back();
        run_window(1'b1, 2'b10, 16'hBBBB, 8'h08, "b2b_first");
        res_ready = 1'b1;
        start     = 1'b1;
        sig_in    = 2'b11;
        step();
        res_ready = 1'b0;
        start     = 1'b0;
        checks++;
        if (busy !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_reprime: got busy=%b valid=%b expected 1 0", busy, res_valid);
        end
        $display("back_to_back: busy=%b valid=%b", busy, res_valid);
        // 00,11,00,11,... after a 11 prime: both nets toggle every comparison
        run_window(1'b0, 2'b11, 16'hCCCC, 8'h88, "b2b_second");
        checks++;
        if (res_toggles !== 8'h88) begin
            errors++;
            $display("FAIL b2b_prime_no_clear: got %h expected 88", res_toggles);
        end
        accept("b2b_second");
    endtask

    task automatic test_abort();
        start  = 1'b1;
        sig_in = 2'b00;
        step();
        start = 1'b0;
        step();                      // prime with 00
        for (int k = 0; k < 4; k++) begin
            sig_in = (k % 2 == 0) ? 2'b01 : 2'b00;
            step();
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || res_toggles !== 8'h00) begin
            errors++;
            $display("FAIL abort_reset: got busy=%b valid=%b toggles=%h expected 0 0 00",
                     busy, res_valid, res_toggles);
        end
        step();
        rst_n = 1'b1;
        $display("abort: busy=%b toggles=%h after mid-window reset", busy, res_toggles);
        // prime 01; samples 01,11,01,11,00,00,01,01 -> net0=2, net1=4
        run_window(1'b1, 2'b01, 16'h50DD, 8'h42, "post_abort");
        accept("post_abort");
    endtask

    initial begin
        test_reset();
        test_quiet();
        test_net0_toggle();
        test_backpressure();
        test_back_to_back();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
